// File: rtl/elevator_scheduler_pkg.sv
// Shared state encodings, direction codes and default timing for the elevator scheduler.
package elevator_scheduler_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;
    localparam logic [1:0] S_DOOR = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int unsigned DEF_FLOORS        = 8;
    localparam int unsigned DEF_FLOOR_W       = 4;
    localparam int unsigned DEF_TRAVEL_CYCLES = 4;
    localparam int unsigned DEF_DOOR_CYCLES   = 3;

endpackage

// File: rtl/elevator_scheduler_call_locator.sv
// Combinational view of the pending set relative to one floor: calls above, below, at it.
module call_locator #(
    parameter int unsigned FLOORS  = 8,
    parameter int unsigned FLOOR_W = 4
) (
    input  logic [FLOORS-1:0]  pend,
    input  logic [FLOOR_W-1:0] floor_idx,
    output logic               above,
    output logic               below,
    output logic               here
);

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_idx)  above = above | pend[i];
            if (FLOOR_W'(i) < floor_idx)  below = below | pend[i];
            if (FLOOR_W'(i) == floor_idx) here  = here  | pend[i];
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: pending-call register, travel/dwell timers and motor/door FSM.
// Optional emergency stop freeze is enabled with ELEVATOR_ESTOP_EN.
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int unsigned FLOORS        = DEF_FLOORS,
    parameter int unsigned FLOOR_W       = DEF_FLOOR_W,
    parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ELEVATOR_ESTOP_EN
    input  logic               estop,
`endif
    input  logic [FLOORS-1:0]  call_req,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               moving_up,
    output logic               moving_down,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending,
    output logic               floor_tick
);

    localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] T_DOOR   = TW'(DOOR_CYCLES - 1);

    logic [1:0]         state, state_n;
    logic [TW-1:0]      timer, timer_n;
    logic               dir_last, dir_n;
    logic [FLOOR_W-1:0] cur_n, nxt_floor;
    logic [FLOORS-1:0]  pend_in, pending_n, clear_mask, cur_mask, nxt_mask;
    logic               tick_n, absorb, freeze;
    logic               above_c, below_c, here_c;
    logic               above_n, below_n, here_n;

`ifdef ELEVATOR_ESTOP_EN
    assign freeze = estop;
`else
    assign freeze = 1'b0;
`endif

    assign nxt_floor = (state == S_DOWN) ? current_floor - FLOOR_W'(1)
                                         : current_floor + FLOOR_W'(1);

    always_comb begin
        cur_mask = '0;
        nxt_mask = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            cur_mask[i] = (current_floor == FLOOR_W'(i));
            nxt_mask[i] = (nxt_floor == FLOOR_W'(i));
        end
    end

    // A call to the floor whose door is already open is absorbed rather than latched.
    assign absorb  = (state == S_DOOR) && |(call_req & cur_mask);
    assign pend_in = (pending | call_req) & ~((state == S_DOOR) ? cur_mask : '0);

    call_locator #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_loc_cur (
        .pend(pend_in), .floor_idx(current_floor),
        .above(above_c), .below(below_c), .here(here_c)
    );

    call_locator #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_loc_nxt (
        .pend(pend_in), .floor_idx(nxt_floor),
        .above(above_n), .below(below_n), .here(here_n)
    );

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        dir_n      = dir_last;
        cur_n      = current_floor;
        tick_n     = 1'b0;
        clear_mask = '0;
        case (state)
            S_IDLE: begin
                if (here_c) begin
                    state_n    = S_DOOR;
                    timer_n    = T_DOOR;
                    clear_mask = cur_mask;
                end else if (above_c) begin
                    state_n = S_UP;
                    timer_n = T_TRAVEL;
                    dir_n   = DIR_UP;
                end else if (below_c) begin
                    state_n = S_DOWN;
                    timer_n = T_TRAVEL;
                    dir_n   = DIR_DOWN;
                end
            end
            S_UP, S_DOWN: begin
                if (timer != '0) begin
                    timer_n = timer - TW'(1);
                end else begin
                    // Arrival: decide using the locator aimed at the floor being entered.
                    cur_n  = nxt_floor;
                    tick_n = 1'b1;
                    if (here_n) begin
                        state_n    = S_DOOR;
                        timer_n    = T_DOOR;
                        clear_mask = nxt_mask;
                    end else if ((state == S_UP) ? above_n : below_n) begin
                        timer_n = T_TRAVEL;
                    end else if ((state == S_UP) ? below_n : above_n) begin
                        state_n = (state == S_UP) ? S_DOWN : S_UP;
                        dir_n   = (state == S_UP) ? DIR_DOWN : DIR_UP;
                        timer_n = T_TRAVEL;
                    end else begin
                        state_n = S_IDLE;
                        timer_n = '0;
                    end
                end
            end
            default: begin
                if (absorb) begin
                    timer_n = T_DOOR;
                end else if (timer != '0) begin
                    timer_n = timer - TW'(1);
                end else if ((dir_last == DIR_UP) ? above_c : below_c) begin
                    state_n = (dir_last == DIR_UP) ? S_UP : S_DOWN;
                    timer_n = T_TRAVEL;
                end else if ((dir_last == DIR_UP) ? below_c : above_c) begin
                    state_n = (dir_last == DIR_UP) ? S_DOWN : S_UP;
                    dir_n   = ~dir_last;
                    timer_n = T_TRAVEL;
                end else begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end
            end
        endcase
        pending_n = pend_in & ~clear_mask;
        if (freeze) begin
            state_n   = state;
            timer_n   = timer;
            dir_n     = dir_last;
            cur_n     = current_floor;
            tick_n    = 1'b0;
            pending_n = pend_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            dir_last      <= DIR_UP;
            current_floor <= '0;
            pending       <= '0;
            floor_tick    <= 1'b0;
            moving_up     <= 1'b0;
            moving_down   <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            dir_last      <= dir_n;
            current_floor <= cur_n;
            pending       <= pending_n;
            floor_tick    <= tick_n;
            moving_up     <= !freeze && (state_n == S_UP);
            moving_down   <= !freeze && (state_n == S_DOWN);
            door_open     <= !freeze && (state_n == S_DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed-vector bench for elevator_scheduler (FLOORS=8, TRAVEL=4, DOOR=3).
// Estop scenario is included when ELEVATOR_ESTOP_EN is defined.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] call_req = '0;
    logic [3:0] current_floor;
    logic       moving_up, moving_down, door_open, floor_tick;
    logic [7:0] pending;
`ifdef ELEVATOR_ESTOP_EN
    logic       estop = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .FLOORS(8), .FLOOR_W(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef ELEVATOR_ESTOP_EN
        .estop(estop),
`endif
        .call_req(call_req),
        .current_floor(current_floor),
        .moving_up(moving_up),
        .moving_down(moving_down),
        .door_open(door_open),
        .pending(pending),
        .floor_tick(floor_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        call_req = '0;
        step(n);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state
        step(2);
        rst = 1'b0;
        check("rst_floor", 32'(current_floor), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_outs", {moving_up, moving_down, door_open, floor_tick}, 0);

        // 2: call floor 3 from 0
        call_req = 8'h08;
        step(1);
        call_req = '0;
        check("t2_up", 32'(moving_up), 1);
        check("t2_pend", 32'(pending), 32'h08);
        step(3);
        check("t2_notick", {28'd0, current_floor}, 0);
        check("t2_tick_lo", 32'(floor_tick), 0);
        step(1);
        check("t2_f1", {floor_tick, current_floor}, {1'b1, 4'd1});
        step(1);
        check("t2_tick_pulse", 32'(floor_tick), 0);
        step(3);
        check("t2_f2", {floor_tick, current_floor}, {1'b1, 4'd2});
        step(4);
        check("t2_f3", {floor_tick, current_floor}, {1'b1, 4'd3});
        check("t2_door", {moving_up, door_open}, 2'b01);
        check("t2_clr", 32'(pending), 0);
        step(2);
        check("t2_door3", 32'(door_open), 1);
        step(1);
        check("t2_idle", {moving_up, moving_down, door_open}, 0);

        // 3: call at idle floor, absorbed re-call restarts dwell
        do_reset(1);
        call_req = 8'h01;
        step(1);
        call_req = '0;
        check("t3_door", 32'(door_open), 1);
        check("t3_pend", 32'(pending), 0);
        step(1);
        call_req = 8'h01;
        step(1);
        call_req = '0;
        check("t3_absorb", {door_open, pending}, {1'b1, 8'h00});
        step(2);
        check("t3_restart", {door_open, pending}, {1'b1, 8'h00});
        step(1);
        check("t3_close", 32'(door_open), 0);

        // 4: SCAN with calls inserted while travelling up past floor 2
        do_reset(1);
        call_req = 8'h20;
        step(1);
        call_req = '0;
        step(8);
        check("t4_at2", {moving_up, current_floor}, {1'b1, 4'd2});
        call_req = 8'h12;
        step(1);
        call_req = '0;
        check("t4_pend", 32'(pending), 32'h32);
        step(3);
        check("t4_pass3", {floor_tick, door_open, current_floor}, {2'b10, 4'd3});
        step(4);
        check("t4_stop4", {door_open, moving_up, current_floor}, {2'b10, 4'd4});
        check("t4_pend4", 32'(pending), 32'h22);
        step(3);
        check("t4_go5", {moving_up, door_open}, 2'b10);
        step(4);
        check("t4_stop5", {door_open, current_floor, pending}, {1'b1, 4'd5, 8'h02});
        step(2);
        check("t4_nodown", {moving_down, door_open}, 2'b01);
        step(1);
        check("t4_down", {moving_down, door_open}, 2'b10);
        step(16);
        check("t4_stop1", {door_open, moving_down, current_floor}, {2'b10, 4'd1});
        check("t4_done", 32'(pending), 0);

        // 5: top floor, no wrap; reset mid-travel
        do_reset(1);
        call_req = 8'h80;
        step(1);
        call_req = '0;
        step(28);
        check("t5_top", {door_open, moving_up, current_floor}, {2'b10, 4'd7});
        step(8);
        check("t5_nowrap", {moving_up, current_floor}, {1'b0, 4'd7});
        call_req = 8'h01;
        step(1);
        call_req = '0;
        check("t5_down", 32'(moving_down), 1);
        step(6);
        check("t5_f6", 32'(current_floor), 6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_rst", {moving_down, current_floor, pending}, 0);

`ifdef ELEVATOR_ESTOP_EN
        // 6: estop freeze mid-travel
        do_reset(1);
        call_req = 8'h08;
        step(1);
        call_req = '0;
        step(2);
        estop = 1'b1;
        step(2);
        call_req = 8'h80;
        step(1);
        call_req = '0;
        step(2);
        check("t6_frozen", {moving_up, door_open, floor_tick, current_floor}, 0);
        check("t6_latch", 32'(pending), 32'h88);
        estop = 1'b0;
        step(1);
        check("t6_resume", {moving_up, floor_tick, current_floor}, {2'b10, 4'd0});
        step(1);
        check("t6_tick", {floor_tick, current_floor}, {1'b1, 4'd1});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
